pc_ctrl: RTL
============

Name: pc_ctrl

Overview:
- Fetch sequencer that owns the program counter's write port.
- Issues instruction-memory reads at the current PC and advances the PC by 4 on each accepted fetch.
- Applies branch/jump redirects from EX, including redirects that arrive during a stall, which are held pending.
- Latches halt and reports it. Sits between the pc register, the icache/imem port and the IF/ID latch.

Parameters:
- PC_INIT, 32'h0000_0000, value driven on pc_next while in reset/idle; matches the pc register reset value.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- pco  in  32  current PC from the pc register.
- pc_wen  out  1  pc register write enable.
- pc_next  out  32  value written to the pc register.
- pc_halt  out  1  halt to the pc register; sticky.
- iren  out  1  instruction read request.
- iaddr  out  32  instruction address; always equals pco.
- ihit  in  1  imem/icache hit; instruction valid this cycle.
- stall  in  1  downstream freeze (hazard unit or dmem wait).
- redirect  in  1  EX resolved taken branch/jump/jr.
- redirect_pc  in  32  redirect target.
- halt_in  in  1  halt instruction decoded.
- if_valid  out  1  fetched instruction accepted into IF/ID this cycle.
- halted  out  1  controller in HALT.
- fetch_cnt  out  CNT_W  count of accepted (non-squashed) fetches.

Behaviour:
- Type and state encoding: word_t (32 bit); states IDLE, FETCH, HOLD, HALT; state register only, outputs combinational from state and inputs unless noted.
- Reset, synchronous on any cycle including mid-fetch or HALT: state=IDLE, pend_valid=0, pend_pc=0, fetch_cnt=0, halted=0, pc_halt=0. Outputs during reset: pc_wen=0, iren=0, if_valid=0, pc_next=PC_INIT.
- Effective redirect: eff_rd = (redirect & !stall) | (pend_valid & !stall); eff_pc = pend_valid ? pend_pc : redirect_pc. A pending redirect is older than the current one and wins.
- Pending register:
  - redirect & stall: pend_valid<=1, pend_pc<=redirect_pc. A later redirect under stall overwrites it; latest wins.
  - Cleared on the first cycle with stall=0, when it is applied.
- IDLE: iren=0; next state FETCH unconditionally.
- FETCH: iren=1. Priority per cycle, highest first:
  1. halt_in & !stall -> pc_halt<=1, halted<=1, HALT; no pc_wen, if_valid=0.
  2. eff_rd -> pc_wen=1, pc_next=eff_pc, if_valid=0 (any concurrent ihit is squashed); stay FETCH.
  3. ihit & !stall -> pc_wen=1, pc_next=pco+4, if_valid=1, fetch_cnt++; stay FETCH.
  4. ihit & stall -> HOLD; pc unchanged.
  5. else: hold, no writes.
- HOLD: iren=0. Same priority as FETCH, except the held instruction counts as the hit. On stall=0 with no halt or redirect: pc_wen=1, pc+4, if_valid=1, fetch_cnt++, -> FETCH. A redirect squashes the held instruction and goes -> FETCH.
- HALT: iren=0, pc_wen=0, if_valid=0. pc_halt and halted stay 1 until RST; all inputs are ignored.
- Arithmetic: pco+4 is modulo 2^32 (32'hFFFF_FFFC -> 0). fetch_cnt saturates at all ones.
- Latency: zero-cycle from ihit to pc_wen/if_valid. Redirect takes effect on the next edge. A redirect stored under stall applies on the first unstalled edge.

Decomposition:
- cpu_types_pkg gains typedef enum logic [1:0] pcc_state_t {PCC_IDLE, PCC_FETCH, PCC_HOLD, PCC_HALT} and localparam word_t PC_STEP = 32'd4; reuse word_t.
- A new pc_ctrl_if interface mirrors the port list with modports pcc and tb.
- One natural sub-module: pcc_pending, the pending-redirect register (set on redirect&stall, clear on !stall, outputs pend_valid/pend_pc). Everything else stays inline.

Test Plan:
- Sequential fetch: reset, pco=0, ihit=1 every cycle, stall=0 for 4 cycles -> pc_next 4,8,C,10 with pc_wen=1 each cycle; if_valid=1 each cycle; fetch_cnt=4.
- Stall hold: ihit=1 with stall=1 for 3 cycles, then stall=0 -> state HOLD, iren=0, pc_wen=0 during stall; single pc_wen with pc_next=pco+4, if_valid=1 on release.
- Redirect with hit: pco=0x40, ihit=1, redirect=1, redirect_pc=0x100 -> pc_wen=1, pc_next=0x100, if_valid=0, fetch_cnt unchanged.
- Pending redirect: stall=1 with redirect to 0x200, then redirect to 0x300 still stalled, then stall=0 -> one pc_wen to 0x300 on the release cycle; pend_valid=0 afterwards.
- Halt priority: halt_in=1, redirect=1, ihit=1 in the same cycle -> next cycle halted=1, pc_halt=1, no pc_wen; later ihit/redirect ignored; RST returns IDLE with halted=0.
- Wrap and reset mid-fetch: pco=0xFFFF_FFFC with ihit -> pc_next=0. Assert RST during HOLD -> next cycle IDLE, iren=0, fetch_cnt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-controller state encoding and PC stride.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PCC_IDLE,
        PCC_FETCH,
        PCC_HOLD,
        PCC_HALT
    } pcc_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/pc_ctrl_if.sv
// Bundle of the fetch-controller signals; pcc is the controller side, tb the driver side.
interface pc_ctrl_if #(
    parameter int CNT_W = 32
) (
    input logic CLK
);
    logic             RST;
    logic [31:0]      pco;
    logic             pc_wen;
    logic [31:0]      pc_next;
    logic             pc_halt;
    logic             iren;
    logic [31:0]      iaddr;
    logic             ihit;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             halt_in;
    logic             if_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;

    modport pcc (
        input  CLK, RST, pco, ihit, stall, redirect, redirect_pc, halt_in,
        output pc_wen, pc_next, pc_halt, iren, iaddr, if_valid, halted, fetch_cnt
    );

    modport tb (
        input  CLK, pc_wen, pc_next, pc_halt, iren, iaddr, if_valid, halted, fetch_cnt,
        output RST, pco, ihit, stall, redirect, redirect_pc, halt_in
    );
endinterface

// File: rtl/pcc_pending.sv
// Holds a redirect that arrived while the pipe was frozen; the latest one wins,
// and it is dropped on the first unstalled cycle, which is when it gets applied.
module pcc_pending (
    input  logic        clk,
    input  logic        srst,
    input  logic        en_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    input  logic [31:0] redirect_pc_i,
    output logic        pend_valid_o,
    output logic [31:0] pend_pc_o
);
    logic        pend_valid_q;
    logic [31:0] pend_pc_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
        end else if (en_i) begin
            if (redirect_i && stall_i) begin
                pend_valid_q <= 1'b1;
                pend_pc_q    <= redirect_pc_i;
            end else if (!stall_i) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_pc_o    = pend_pc_q;
endmodule

// File: rtl/pc_ctrl.sv
// Fetch sequencer: drives the PC write port, the imem read request and the IF/ID accept,
// resolving halt > redirect > sequential hit each cycle.
module pc_ctrl
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      pco,
    output logic             pc_wen,
    output logic [31:0]      pc_next,
    output logic             pc_halt,
    output logic             iren,
    output logic [31:0]      iaddr,
    input  logic             ihit,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_in,
    output logic             if_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);
    pcc_state_t       state_q, state_d;
    logic             halted_q;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic             pend_valid;
    word_t            pend_pc;
    logic             eff_rd;
    word_t            eff_pc;
    logic             halt_take;
    logic             hit_take;

    pcc_pending u_pend (
        .clk          (CLK),
        .srst         (RST),
        .en_i         (state_q != PCC_HALT),
        .redirect_i   (redirect),
        .stall_i      (stall),
        .redirect_pc_i(redirect_pc),
        .pend_valid_o (pend_valid),
        .pend_pc_o    (pend_pc)
    );

    // A pending redirect is older than one arriving now, so it takes precedence.
    assign eff_rd    = (redirect || pend_valid) && !stall;
    assign eff_pc    = pend_valid ? pend_pc : redirect_pc;
    assign halt_take = halt_in && !stall;
    // In HOLD the instruction already captured counts as the hit.
    assign hit_take  = (state_q == PCC_HOLD) ? !stall : (ihit && !stall);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= PCC_IDLE;
            halted_q    <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            if (state_d == PCC_HALT)
                halted_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PCC_IDLE:  state_d = PCC_FETCH;
            PCC_FETCH: begin
                if (halt_take)
                    state_d = PCC_HALT;
                else if (!eff_rd && !hit_take && ihit && stall)
                    state_d = PCC_HOLD;
            end
            PCC_HOLD: begin
                if (halt_take)
                    state_d = PCC_HALT;
                else if (eff_rd || hit_take)
                    state_d = PCC_FETCH;
            end
            PCC_HALT:  state_d = PCC_HALT;
            default:   state_d = PCC_IDLE;
        endcase
    end

    always_comb begin
        pc_wen      = 1'b0;
        pc_next     = pco;
        iren        = 1'b0;
        if_valid    = 1'b0;
        fetch_cnt_d = fetch_cnt_q;
        if (RST || state_q == PCC_IDLE) begin
            pc_next = PC_INIT;
        end else if (state_q == PCC_FETCH || state_q == PCC_HOLD) begin
            iren = (state_q == PCC_FETCH);
            if (!halt_take) begin
                if (eff_rd) begin
                    pc_wen  = 1'b1;
                    pc_next = eff_pc;
                end else if (hit_take) begin
                    pc_wen   = 1'b1;
                    pc_next  = pco + PC_STEP;
                    if_valid = 1'b1;
                    if (!(&fetch_cnt_q))
                        fetch_cnt_d = fetch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign iaddr     = pco;
    assign halted    = halted_q;
    assign pc_halt   = halted_q;
    assign fetch_cnt = fetch_cnt_q;
endmodule
